// File: rtl/prog_rom_loader_if.sv
// Download-port bundle between the HPS ioctl source and the program-ROM writer.
// Latency: none (wires only).
// Backpressure: none; the ioctl stream is fire-and-forget, one byte per ioctl_wr.
//
// Signals:
//   ioctl_download/ioctl_index/ioctl_wr/ioctl_addr/ioctl_dout : HPS byte stream
//   dn_wr/dn_addr/dn_data                                     : ROM write port
// Modports:
//   master : the side that produces the ioctl stream and observes the ROM writes
//   slave  : the loader, which consumes ioctl and drives the ROM write port
interface prog_rom_loader_if;
    logic        ioctl_download;
    logic [7:0]  ioctl_index;
    logic        ioctl_wr;
    logic [24:0] ioctl_addr;
    logic [7:0]  ioctl_dout;

    logic        dn_wr;
    logic [15:0] dn_addr;
    logic [7:0]  dn_data;

    modport master (
        output ioctl_download,
        output ioctl_index,
        output ioctl_wr,
        output ioctl_addr,
        output ioctl_dout,
        input  dn_wr,
        input  dn_addr,
        input  dn_data
    );

    modport slave (
        input  ioctl_download,
        input  ioctl_index,
        input  ioctl_wr,
        input  ioctl_addr,
        input  ioctl_dout,
        output dn_wr,
        output dn_addr,
        output dn_data
    );
endinterface

// File: rtl/prog_rom_loader.sv
// Program-ROM loader: turns the HPS ioctl byte stream into ROM writes and gates CPU reset.
// Latency: each accepted byte appears on dn_wr/dn_addr/dn_data exactly 1 clk after ioctl_wr.
// Backpressure: none; every in-range byte of the active image is written, others are dropped.
//
// Ports:
//   clk_i            download clock (also the ROM b_clk)
//   resetn_i         synchronous active-low reset
//   io               prog_rom_loader_if.slave: ioctl stream in, dn_* ROM write port out
//   cpu_reset_hold_o 1 = keep the CPU in reset (everywhere except RUN)
//   rom_loaded_o     1 = the last load had the expected byte count and no dropped bytes
//   addr_overflow_o  sticky: a byte at ioctl_addr >= 25'h10000 was dropped this load
//   checksum_o, checksum_ok_o   only when ROM_CHECKSUM_EN is defined
//
// Optional feature macro: ROM_CHECKSUM_EN adds an 8-bit wrap-around sum of the written
// bytes, compares it with EXPECTED_SUM and makes that match part of the load check.
module prog_rom_loader #(
    parameter logic [7:0]  ROM_INDEX    = 8'd0,
    parameter logic [16:0] LOAD_SIZE    = 17'h10000,
    parameter logic [15:0] HOLD_CYCLES  = 16'd1024
`ifdef ROM_CHECKSUM_EN
    ,
    parameter logic [7:0]  EXPECTED_SUM = 8'h00
`endif
) (
    input  logic                   clk_i,
    input  logic                   resetn_i,
    prog_rom_loader_if.slave       io,
    output logic                   cpu_reset_hold_o,
    output logic                   rom_loaded_o,
    output logic                   addr_overflow_o
`ifdef ROM_CHECKSUM_EN
    ,
    output logic [7:0]             checksum_o,
    output logic                   checksum_ok_o
`endif
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_CHECK = 3'd2,
        S_HOLD  = 3'd3,
        S_RUN   = 3'd4,
        S_FAIL  = 3'd5
    } state_t;

    localparam logic [15:0] HOLD_LAST = HOLD_CYCLES - 16'd1;
    localparam logic [16:0] CNT_MAX   = 17'h1FFFF;

    state_t      state_q, state_d;
    logic        dn_wr_q, dn_wr_d;
    logic [15:0] dn_addr_q, dn_addr_d;
    logic [7:0]  dn_data_q, dn_data_d;
    logic [16:0] byte_cnt_q, byte_cnt_d;
    logic [15:0] hold_cnt_q, hold_cnt_d;
    logic        rom_loaded_q, rom_loaded_d;
    logic        ovf_q, ovf_d;

    logic        our_index;
    logic        active;
    logic        in_range;
    logic        load_ok;

`ifdef ROM_CHECKSUM_EN
    logic [7:0]  sum_q, sum_d;
    logic        sum_ok;
    assign sum_ok = (sum_q == EXPECTED_SUM);
`endif

    // A byte is in range only when all address bits above the 64 KiB ROM space are zero.
    assign our_index = (io.ioctl_index == ROM_INDEX);
    assign active    = io.ioctl_download && our_index;
    assign in_range  = (io.ioctl_addr[24:16] == 9'd0);

`ifdef ROM_CHECKSUM_EN
    assign load_ok = (byte_cnt_q == LOAD_SIZE) && !ovf_q && sum_ok;
`else
    assign load_ok = (byte_cnt_q == LOAD_SIZE) && !ovf_q;
`endif

    always_comb begin
        state_d      = state_q;
        dn_wr_d      = 1'b0;
        dn_addr_d    = dn_addr_q;
        dn_data_d    = dn_data_q;
        byte_cnt_d   = byte_cnt_q;
        hold_cnt_d   = hold_cnt_q;
        rom_loaded_d = rom_loaded_q;
        ovf_d        = ovf_q;
`ifdef ROM_CHECKSUM_EN
        sum_d        = sum_q;
`endif

        case (state_q)
            S_IDLE, S_HOLD, S_RUN, S_FAIL: begin
                if (active) begin
                    // A new image restarts everything; status from the previous load is void.
                    state_d      = S_LOAD;
                    byte_cnt_d   = 17'd0;
                    hold_cnt_d   = 16'd0;
                    rom_loaded_d = 1'b0;
                    ovf_d        = 1'b0;
`ifdef ROM_CHECKSUM_EN
                    sum_d        = 8'h00;
`endif
                end else if (state_q == S_HOLD) begin
                    if (hold_cnt_q == HOLD_LAST) begin
                        state_d = S_RUN;
                    end else begin
                        hold_cnt_d = hold_cnt_q + 16'd1;
                    end
                end
            end

            S_LOAD: begin
                // The index qualifier keeps a byte of a different image out of the ROM on the
                // cycle the index switches; a byte on the cycle download falls is still ours.
                if (io.ioctl_wr && our_index) begin
                    if (in_range) begin
                        dn_wr_d   = 1'b1;
                        dn_addr_d = io.ioctl_addr[15:0];
                        dn_data_d = io.ioctl_dout;
                        if (byte_cnt_q != CNT_MAX) begin
                            byte_cnt_d = byte_cnt_q + 17'd1;
                        end
`ifdef ROM_CHECKSUM_EN
                        sum_d = sum_q + io.ioctl_dout;
`endif
                    end else begin
                        ovf_d = 1'b1;
                    end
                end
                if (!active) begin
                    state_d = S_CHECK;
                end
            end

            S_CHECK: begin
                if (load_ok) begin
                    rom_loaded_d = 1'b1;
                    hold_cnt_d   = 16'd0;
                    state_d      = (HOLD_CYCLES == 16'd0) ? S_RUN : S_HOLD;
                end else begin
                    state_d = S_FAIL;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!resetn_i) begin
            state_q      <= S_IDLE;
            dn_wr_q      <= 1'b0;
            dn_addr_q    <= 16'd0;
            dn_data_q    <= 8'd0;
            byte_cnt_q   <= 17'd0;
            hold_cnt_q   <= 16'd0;
            rom_loaded_q <= 1'b0;
            ovf_q        <= 1'b0;
`ifdef ROM_CHECKSUM_EN
            sum_q        <= 8'h00;
`endif
        end else begin
            state_q      <= state_d;
            dn_wr_q      <= dn_wr_d;
            dn_addr_q    <= dn_addr_d;
            dn_data_q    <= dn_data_d;
            byte_cnt_q   <= byte_cnt_d;
            hold_cnt_q   <= hold_cnt_d;
            rom_loaded_q <= rom_loaded_d;
            ovf_q        <= ovf_d;
`ifdef ROM_CHECKSUM_EN
            sum_q        <= sum_d;
`endif
        end
    end

    assign io.dn_wr   = dn_wr_q;
    assign io.dn_addr = dn_addr_q;
    assign io.dn_data = dn_data_q;

    // The CPU may only run once the post-load hold has expired.
    assign cpu_reset_hold_o = (state_q != S_RUN);
    assign rom_loaded_o     = rom_loaded_q;
    assign addr_overflow_o  = ovf_q;

`ifdef ROM_CHECKSUM_EN
    assign checksum_o    = sum_q;
    assign checksum_ok_o = sum_ok;
`endif

endmodule

// File: doc/prog_rom_loader.md
Name: prog_rom_loader

Overview:
- Writer side of the program-ROM download port. Converts the HPS ioctl byte stream into single-cycle dn_wr/dn_addr/dn_data writes for the dual-port program ROMs.
- Holds the CPU in reset during and shortly after the load.
- Tracks load completeness and flags out-of-range bytes.
- Sits between hps_io and the program memory block, on the download clock domain.

Parameters:
- ROM_INDEX, 8'd0: ioctl_index value accepted as the program ROM image.
- LOAD_SIZE, 17'h10000: expected byte count for a complete image.
- HOLD_CYCLES, 16'd1024: clocks cpu_reset_hold stays high after a successful load.
- EXPECTED_SUM, 8'h00: reference 8-bit sum (used only with ROM_CHECKSUM_EN).

Ports:
- clk  in  1  download clock; same clock drives the ROM b_clk.
- resetn  in  1  synchronous active-low reset.
- ioctl_download  in  1  high while HPS transfers an image.
- ioctl_index  in  8  image selector.
- ioctl_wr  in  1  byte strobe, one cycle per byte.
- ioctl_addr  in  25  byte address within image.
- ioctl_dout  in  8  byte data.
- dn_wr  out  1  single-cycle write strobe to the ROMs.
- dn_addr  out  16  ROM write address (bits [15:13] select the chip).
- dn_data  out  8  ROM write data.
- cpu_reset_hold  out  1  high = keep CPU in reset.
- rom_loaded  out  1  high = last load complete and valid.
- addr_overflow  out  1  sticky; a byte with ioctl_addr >= 25'h10000 was dropped.

Behaviour:
- Reset values (resetn=0 at a clk edge):
  - state = IDLE; dn_wr = 0; dn_addr = 0; dn_data = 0.
  - cpu_reset_hold = 1; rom_loaded = 0; addr_overflow = 0; byte counter = 0; hold counter = 0.
- Active download: ioctl_download=1 and ioctl_index==ROM_INDEX. Other indices are ignored entirely; outputs and state are unchanged.
- States:
  - IDLE: on active download -> LOAD. Clear counter, rom_loaded and addr_overflow; set cpu_reset_hold=1.
  - LOAD: each ioctl_wr=1 cycle with ioctl_addr < 25'h10000 produces, next cycle:
    - dn_wr=1, dn_addr=ioctl_addr[15:0], dn_data=ioctl_dout;
    - byte counter +1 (17-bit, saturating at 17'h1FFFF).
    - Latency is exactly 1 clk; dn_wr is never high two consecutive cycles unless ioctl_wr was.
  - LOAD, out-of-range byte (ioctl_addr >= 25'h10000): no dn_wr, no count; addr_overflow <= 1.
  - LOAD -> CHECK when ioctl_download falls or ioctl_index changes.
  - CHECK (1 cycle):
    - If counter == LOAD_SIZE and addr_overflow == 0 (and checksum ok when enabled): rom_loaded <= 1 -> HOLD.
    - Otherwise -> FAIL.
  - HOLD: cpu_reset_hold=1; hold counter counts 0..HOLD_CYCLES-1, then -> RUN.
  - RUN: cpu_reset_hold=0.
  - FAIL: cpu_reset_hold=1, rom_loaded=0.
  - From HOLD, RUN or FAIL, a new active download -> LOAD with all status cleared.
- Simultaneous events:
  - An ioctl_wr on the same cycle ioctl_download falls is still written and counted.
  - HOLD_CYCLES=0 goes CHECK -> RUN directly.
- Duplicate addresses: each written byte is counted even if its address repeats. Completeness is a count check only.
- Reset mid-load: returns to IDLE; rom_loaded=0; CPU held. The partially written ROM content is not cleared.

Optional Feature:
- Macro ROM_CHECKSUM_EN.
- When defined:
  - 8-bit wrap-around sum of all written dn_data, cleared on LOAD entry.
  - Extra outputs checksum[7:0] and checksum_ok. checksum_ok is valid from CHECK onward and is 1 iff sum == EXPECTED_SUM.
  - CHECK additionally requires checksum_ok=1.
- When undefined: no summing logic, no extra ports, and CHECK ignores the checksum.

Test Plan:
1. Reset, then index 0 download of 65536 bytes (addr 0..FFFF, data=addr[7:0]), HOLD_CYCLES=4 -> dn_wr pulses 65536 times, each 1 clk after ioctl_wr with matching addr/data; rom_loaded=1 two clks after download falls; cpu_reset_hold falls exactly 4 clks after HOLD entry.
2. Download with index 1 -> zero dn_wr pulses, state stays IDLE, cpu_reset_hold=1.
3. Download of 100 bytes then ioctl_download=0 -> FAIL; rom_loaded=0; cpu_reset_hold=1. A following full index 0 download recovers to RUN.
4. Full image plus one byte at ioctl_addr=25'h10000 -> no dn_wr for that byte; addr_overflow=1; FAIL.
5. resetn=0 after 5000 bytes, then resetn=1 -> all outputs at reset values, IDLE; a following ioctl_wr with ioctl_download=0 gives no dn_wr.
6. With ROM_CHECKSUM_EN: full image all 8'h01, EXPECTED_SUM=8'h00 -> checksum=8'h00, checksum_ok=1, RUN. With one byte changed to 8'h02 -> checksum=8'h01, FAIL.
